// File: rtl/srec_axil_mem_responder_if.sv
// AXI4-Lite bundle between the SREC boot loader master port and the memory responder.
interface srec_axil_mem_responder_if #(
  parameter int unsigned ADDR_WIDTH = 32
) ();
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [2:0]            awprot;
  logic                  awvalid;
  logic                  awready;
  logic [31:0]           wdata;
  logic [3:0]            wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;
  logic [31:0]           rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/srec_axil_mem_responder.sv
// AXI4-Lite word memory responder with independent write/read FSMs and saturating counters.
// Optional SREC_RESP_SLVERR_EN: out-of-range word indices return SLVERR instead of wrapping.
module srec_axil_mem_responder #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned MEM_DEPTH  = 256,
  parameter logic [31:0] INIT_VALUE = 32'h0000_0000
) (
  input  logic                            aclk,
  input  logic                            aresetn,
  srec_axil_mem_responder_if.slave        s_axi,
  output logic [15:0]                     wr_cnt,
  output logic [15:0]                     rd_cnt
);
  localparam int unsigned IdxW   = $clog2(MEM_DEPTH);
  localparam logic [1:0]  Okay   = 2'b00;
  localparam logic [1:0]  SlvErr = 2'b10;

  typedef enum logic [1:0] {StWIdle, StWHaveAw, StWHaveW, StWResp} wr_st_e;
  typedef enum logic {StRIdle, StRResp} rd_st_e;

  wr_st_e            wr_st_q;
  rd_st_e            rd_st_q;
  logic              awready_q, wready_q, bvalid_q, arready_q, rvalid_q;
  logic [1:0]        bresp_q, rresp_q;
  logic [31:0]       rdata_q;
  logic [15:0]       wr_cnt_q, rd_cnt_q;
  logic [IdxW-1:0]   aw_idx_q;
  logic              aw_err_q;
  logic [31:0]       wdata_q;
  logic [3:0]        wstrb_q;
  logic [31:0]       mem_q [MEM_DEPTH];

  logic [ADDR_WIDTH-1:0] awaddr, araddr;
  logic [IdxW-1:0]       aw_idx, ar_idx, mem_widx;
  logic                  aw_err, ar_err, mem_werr, mem_we;
  logic                  aw_hs, w_hs, ar_hs;
  logic [31:0]           mem_wdata;
  logic [3:0]            mem_wstrb;
  logic                  unused_in;

  assign awaddr    = s_axi.awaddr;
  assign araddr    = s_axi.araddr;
  assign aw_idx    = awaddr[IdxW+1:2];
  assign ar_idx    = araddr[IdxW+1:2];
  assign aw_hs     = s_axi.awvalid & awready_q;
  assign w_hs      = s_axi.wvalid & wready_q;
  assign ar_hs     = s_axi.arvalid & arready_q;
  assign unused_in = ^{s_axi.awprot, s_axi.arprot, awaddr, araddr};

`ifdef SREC_RESP_SLVERR_EN
  assign aw_err = (awaddr >> (IdxW + 2)) != '0;
  assign ar_err = (araddr >> (IdxW + 2)) != '0;
`else
  assign aw_err = 1'b0;
  assign ar_err = 1'b0;
`endif

  // The memory write fires on the edge that completes the second of the AW/W handshakes.
  always_comb begin
    mem_we    = 1'b0;
    mem_widx  = aw_idx;
    mem_werr  = aw_err;
    mem_wdata = s_axi.wdata;
    mem_wstrb = s_axi.wstrb;
    unique case (wr_st_q)
      StWIdle:   mem_we = aw_hs & w_hs;
      StWHaveAw: begin
        mem_we   = w_hs;
        mem_widx = aw_idx_q;
        mem_werr = aw_err_q;
      end
      StWHaveW:  begin
        mem_we    = aw_hs;
        mem_wdata = wdata_q;
        mem_wstrb = wstrb_q;
      end
      default:   mem_we = 1'b0;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < int'(MEM_DEPTH); i++) mem_q[i] <= INIT_VALUE;
    end else if (mem_we && !mem_werr) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_wstrb[b]) mem_q[mem_widx][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_st_q   <= StWIdle;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= Okay;
      wr_cnt_q  <= '0;
      aw_idx_q  <= '0;
      aw_err_q  <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else if (mem_we) begin
      wr_st_q   <= StWResp;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b1;
      bresp_q   <= mem_werr ? SlvErr : Okay;
    end else begin
      unique case (wr_st_q)
        StWIdle: begin
          if (aw_hs) begin
            aw_idx_q  <= aw_idx;
            aw_err_q  <= aw_err;
            awready_q <= 1'b0;
            wready_q  <= 1'b1;
            wr_st_q   <= StWHaveAw;
          end else if (w_hs) begin
            wdata_q   <= s_axi.wdata;
            wstrb_q   <= s_axi.wstrb;
            awready_q <= 1'b1;
            wready_q  <= 1'b0;
            wr_st_q   <= StWHaveW;
          end else begin
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
          end
        end
        StWResp: begin
          if (s_axi.bready) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            wr_st_q   <= StWIdle;
            if (wr_cnt_q != 16'hFFFF) wr_cnt_q <= wr_cnt_q + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Read data is sampled before any same-cycle write lands, so the old word is returned.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rd_st_q   <= StRIdle;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rresp_q   <= Okay;
      rdata_q   <= '0;
      rd_cnt_q  <= '0;
    end else begin
      unique case (rd_st_q)
        StRIdle: begin
          if (ar_hs) begin
            rdata_q   <= ar_err ? '0 : mem_q[ar_idx];
            rresp_q   <= ar_err ? SlvErr : Okay;
            rvalid_q  <= 1'b1;
            arready_q <= 1'b0;
            rd_st_q   <= StRResp;
          end else begin
            arready_q <= 1'b1;
          end
        end
        StRResp: begin
          if (s_axi.rready) begin
            rvalid_q  <= 1'b0;
            arready_q <= 1'b1;
            rd_st_q   <= StRIdle;
            if (rd_cnt_q != 16'hFFFF) rd_cnt_q <= rd_cnt_q + 16'd1;
          end
        end
        default: rd_st_q <= StRIdle;
      endcase
    end
  end

  assign s_axi.awready = awready_q;
  assign s_axi.wready  = wready_q;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bresp   = bresp_q;
  assign s_axi.arready = arready_q;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rresp   = rresp_q;
  assign s_axi.rdata   = rdata_q;
  assign wr_cnt        = wr_cnt_q;
  assign rd_cnt        = rd_cnt_q;
endmodule

// File: tb/tb_srec_axil_mem_responder.sv
// Directed bench for srec_axil_mem_responder: handshakes, latency, strobes, stalls, range, reset.
module tb_srec_axil_mem_responder;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] wr_cnt, rd_cnt;
  int          n_cmp = 0;
  int          n_err = 0;
  int          exp_wr = 0;
  int          exp_rd = 0;

  srec_axil_mem_responder_if #(.ADDR_WIDTH(32)) bus ();

  srec_axil_mem_responder #(
    .ADDR_WIDTH(32),
    .MEM_DEPTH (256),
    .INIT_VALUE(32'h0000_0000)
  ) dut (
    .aclk   (clk),
    .aresetn(rst_n),
    .s_axi  (bus),
    .wr_cnt (wr_cnt),
    .rd_cnt (rd_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, limit 200000", $time);
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                    output logic [1:0] resp, output bit ok);
    bit aw_done, w_done, hs_aw, hs_w;
    bus.awaddr = addr; bus.awvalid = 1'b1;
    bus.wdata = data; bus.wstrb = strb; bus.wvalid = 1'b1; bus.bready = 1'b1;
    aw_done = 1'b0; w_done = 1'b0; ok = 1'b0; resp = 2'b11;
    for (int i = 0; i < 10 && !(aw_done && w_done); i++) begin
      hs_aw = bus.awvalid && bus.awready;
      hs_w  = bus.wvalid && bus.wready;
      step();
      if (hs_aw) begin aw_done = 1'b1; bus.awvalid = 1'b0; end
      if (hs_w) begin w_done = 1'b1; bus.wvalid = 1'b0; end
    end
    for (int i = 0; i < 10 && !ok; i++) begin
      if (bus.bvalid) begin resp = bus.bresp; ok = 1'b1; end
      step();
    end
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    if (ok) exp_wr++;
  endtask

  task automatic rd(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp,
                    output bit ok);
    bit hs;
    bus.araddr = addr; bus.arvalid = 1'b1; bus.rready = 1'b1;
    ok = 1'b0; data = 32'hx; resp = 2'b11;
    for (int i = 0; i < 10 && bus.arvalid; i++) begin
      hs = bus.arready;
      step();
      if (hs) bus.arvalid = 1'b0;
    end
    for (int i = 0; i < 10 && !ok; i++) begin
      if (bus.rvalid) begin data = bus.rdata; resp = bus.rresp; ok = 1'b1; end
      step();
    end
    bus.arvalid = 1'b0;
    if (ok) exp_rd++;
  endtask

  task automatic test_reset();
    bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 0; bus.wdata = '0; bus.wstrb = '0;
    bus.wvalid = 0; bus.bready = 0; bus.araddr = '0; bus.arprot = '0; bus.arvalid = 0;
    bus.rready = 0;
    #2 rst_n = 1'b0;
    step(); step();
    n_cmp++; if (bus.awready !== 1'b0) begin n_err++; $display("FAIL rst_awready: got %b want 0", bus.awready); end
    n_cmp++; if (bus.wready !== 1'b0) begin n_err++; $display("FAIL rst_wready: got %b want 0", bus.wready); end
    n_cmp++; if (bus.arready !== 1'b0) begin n_err++; $display("FAIL rst_arready: got %b want 0", bus.arready); end
    n_cmp++; if ({bus.bvalid, bus.rvalid} !== 2'b00) begin n_err++; $display("FAIL rst_valids: got %b want 00", {bus.bvalid, bus.rvalid}); end
    n_cmp++; if ({bus.bresp, bus.rresp, bus.rdata} !== 36'h0) begin n_err++; $display("FAIL rst_data: got %h want 0", {bus.bresp, bus.rresp, bus.rdata}); end
    n_cmp++; if ({wr_cnt, rd_cnt} !== 32'h0) begin n_err++; $display("FAIL rst_cnt: got %h want 0", {wr_cnt, rd_cnt}); end
    @(negedge clk); rst_n = 1'b1;
    #1;
    n_cmp++; if (bus.awready !== 1'b0) begin n_err++; $display("FAIL rel_ready_early: got %b want 0", bus.awready); end
    step();
    n_cmp++; if ({bus.awready, bus.wready, bus.arready} !== 3'b111) begin n_err++; $display("FAIL rel_ready: got %b want 111", {bus.awready, bus.wready, bus.arready}); end
  endtask

  task automatic test_write_same_cycle();
    bus.awaddr = 32'h10; bus.awvalid = 1; bus.wdata = 32'hDEADBEEF; bus.wstrb = 4'hF;
    bus.wvalid = 1; bus.bready = 1;
    step();
    bus.awvalid = 0; bus.wvalid = 0;
    n_cmp++; if (bus.bvalid !== 1'b1) begin n_err++; $display("FAIL wsc_bvalid: got %b want 1", bus.bvalid); end
    n_cmp++; if (bus.bresp !== 2'b00) begin n_err++; $display("FAIL wsc_bresp: got %b want 00", bus.bresp); end
    n_cmp++; if ({bus.awready, bus.wready} !== 2'b00) begin n_err++; $display("FAIL wsc_ready_resp: got %b want 00", {bus.awready, bus.wready}); end
    step(); exp_wr++;
    n_cmp++; if (bus.bvalid !== 1'b0 || wr_cnt !== 16'd1) begin n_err++; $display("FAIL wsc_bdone: got bvalid %b cnt %0d want 0/1", bus.bvalid, wr_cnt); end
    bus.araddr = 32'h10; bus.arvalid = 1; bus.rready = 1;
    step();
    bus.arvalid = 0;
    n_cmp++; if (bus.rvalid !== 1'b1 || bus.rdata !== 32'hDEADBEEF || bus.rresp !== 2'b00) begin n_err++; $display("FAIL wsc_read: got %b %h %b want 1 deadbeef 00", bus.rvalid, bus.rdata, bus.rresp); end
    step(); exp_rd++;
    n_cmp++; if (rd_cnt !== 16'd1 || bus.rvalid !== 1'b0) begin n_err++; $display("FAIL wsc_rdcnt: got %0d/%b want 1/0", rd_cnt, bus.rvalid); end
  endtask

  task automatic test_w_before_aw();
    logic [31:0] d; logic [1:0] r; bit ok;
    bus.wdata = 32'h12345678; bus.wstrb = 4'hF; bus.wvalid = 1; bus.bready = 1;
    step();
    bus.wvalid = 0;
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if ({bus.wready, bus.awready, bus.bvalid} !== 3'b010) begin n_err++; $display("FAIL wbw_wait: got %b want 010", {bus.wready, bus.awready, bus.bvalid}); end
      if (i < 2) step();
    end
    bus.awaddr = 32'h4; bus.awvalid = 1;
    step();
    bus.awvalid = 0;
    n_cmp++; if (bus.bvalid !== 1'b1) begin n_err++; $display("FAIL wbw_bvalid: got %b want 1", bus.bvalid); end
    step(); exp_wr++;
    rd(32'h4, d, r, ok);
    n_cmp++; if (!ok || d !== 32'h12345678) begin n_err++; $display("FAIL wbw_readback: got %h ok %b want 12345678", d, ok); end
  endtask

  task automatic test_partial_strobe();
    logic [31:0] d; logic [1:0] r; bit ok;
    wr(32'h20, 32'h11223344, 4'hF, r, ok);
    wr(32'h20, 32'hAABBCCDD, 4'b0101, r, ok);
    rd(32'h20, d, r, ok);
    n_cmp++; if (!ok || d !== 32'h11BB33DD) begin n_err++; $display("FAIL strb_0101: got %h want 11bb33dd", d); end
    wr(32'h20, 32'hFFFFFFFF, 4'h0, r, ok);
    n_cmp++; if (!ok || r !== 2'b00) begin n_err++; $display("FAIL strb_zero_resp: got %b ok %b want 00", r, ok); end
    rd(32'h20, d, r, ok);
    n_cmp++; if (!ok || d !== 32'h11BB33DD) begin n_err++; $display("FAIL strb_zero_noop: got %h want 11bb33dd", d); end
  endtask

  task automatic test_stall();
    logic [31:0] d; logic [1:0] r; bit ok;
    bus.bready = 0; bus.rready = 0;
    bus.awaddr = 32'h30; bus.awvalid = 1; bus.wdata = 32'hCAFEF00D; bus.wstrb = 4'hF;
    bus.wvalid = 1; bus.araddr = 32'h30; bus.arvalid = 1;
    step();
    bus.awvalid = 0; bus.wvalid = 0; bus.arvalid = 0;
    for (int i = 0; i < 6; i++) begin
      n_cmp++; if ({bus.bvalid, bus.rvalid, bus.bresp, bus.rresp} !== 6'b110000) begin n_err++; $display("FAIL stall_valid: got %b want 110000", {bus.bvalid, bus.rvalid, bus.bresp, bus.rresp}); end
      n_cmp++; if (bus.rdata !== 32'h0) begin n_err++; $display("FAIL stall_old_rdata: got %h want 0", bus.rdata); end
      n_cmp++; if ({bus.awready, bus.wready, bus.arready} !== 3'b000) begin n_err++; $display("FAIL stall_ready: got %b want 000", {bus.awready, bus.wready, bus.arready}); end
      n_cmp++; if (wr_cnt !== 16'(exp_wr) || rd_cnt !== 16'(exp_rd)) begin n_err++; $display("FAIL stall_cnt: got %0d/%0d want %0d/%0d", wr_cnt, rd_cnt, exp_wr, exp_rd); end
      if (i < 5) step();
    end
    bus.bready = 1; bus.rready = 1;
    step(); exp_wr++; exp_rd++;
    n_cmp++; if ({bus.bvalid, bus.rvalid} !== 2'b00 || wr_cnt !== 16'(exp_wr) || rd_cnt !== 16'(exp_rd)) begin n_err++; $display("FAIL stall_release: got %b %0d/%0d want 00 %0d/%0d", {bus.bvalid, bus.rvalid}, wr_cnt, rd_cnt, exp_wr, exp_rd); end
    rd(32'h30, d, r, ok);
    n_cmp++; if (!ok || d !== 32'hCAFEF00D) begin n_err++; $display("FAIL stall_readback: got %h want cafef00d", d); end
  endtask

  task automatic test_back_to_back();
    bus.awvalid = 1; bus.wvalid = 1; bus.wstrb = 4'hF; bus.bready = 1;
    for (int k = 0; k < 4; k++) begin
      bus.awaddr = 32'h40 + 32'(4 * k); bus.wdata = 32'hA0000000 + 32'(k);
      step();
      n_cmp++; if ({bus.bvalid, bus.awready} !== 2'b10) begin n_err++; $display("FAIL b2b_wr_resp%0d: got %b want 10", k, {bus.bvalid, bus.awready}); end
      step();
      n_cmp++; if ({bus.bvalid, bus.awready} !== 2'b01) begin n_err++; $display("FAIL b2b_wr_idle%0d: got %b want 01", k, {bus.bvalid, bus.awready}); end
    end
    bus.awvalid = 0; bus.wvalid = 0; exp_wr += 4;
    bus.arvalid = 1; bus.rready = 1;
    for (int k = 0; k < 4; k++) begin
      bus.araddr = 32'h40 + 32'(4 * k);
      step();
      n_cmp++; if (bus.rvalid !== 1'b1 || bus.rdata !== 32'hA0000000 + 32'(k)) begin n_err++; $display("FAIL b2b_rd%0d: got %b %h want 1 %h", k, bus.rvalid, bus.rdata, 32'hA0000000 + 32'(k)); end
      step();
      n_cmp++; if ({bus.rvalid, bus.arready} !== 2'b01) begin n_err++; $display("FAIL b2b_rd_idle%0d: got %b want 01", k, {bus.rvalid, bus.arready}); end
    end
    bus.arvalid = 0; exp_rd += 4;
    n_cmp++; if (wr_cnt !== 16'(exp_wr) || rd_cnt !== 16'(exp_rd)) begin n_err++; $display("FAIL b2b_cnt: got %0d/%0d want %0d/%0d", wr_cnt, rd_cnt, exp_wr, exp_rd); end
  endtask

  task automatic test_out_of_range();
    logic [31:0] d; logic [1:0] r; bit ok;
    logic [31:0] exp_w1, exp_oob_d; logic [1:0] exp_resp;
`ifdef SREC_RESP_SLVERR_EN
    exp_resp = 2'b10; exp_w1 = 32'h12345678; exp_oob_d = 32'h0;
`else
    exp_resp = 2'b00; exp_w1 = 32'h55555555; exp_oob_d = 32'h0BADF00D;
`endif
    wr(32'h0, 32'h0BADF00D, 4'hF, r, ok);
    wr(32'h404, 32'h55555555, 4'hF, r, ok);
    n_cmp++; if (!ok || r !== exp_resp) begin n_err++; $display("FAIL oob_wr_resp: got %b want %b", r, exp_resp); end
    rd(32'h4, d, r, ok);
    n_cmp++; if (!ok || d !== exp_w1) begin n_err++; $display("FAIL oob_wr_effect: got %h want %h", d, exp_w1); end
    rd(32'h400, d, r, ok);
    n_cmp++; if (!ok || d !== exp_oob_d || r !== exp_resp) begin n_err++; $display("FAIL oob_rd: got %h/%b want %h/%b", d, r, exp_oob_d, exp_resp); end
    n_cmp++; if (wr_cnt !== 16'(exp_wr) || rd_cnt !== 16'(exp_rd)) begin n_err++; $display("FAIL oob_cnt: got %0d/%0d want %0d/%0d", wr_cnt, rd_cnt, exp_wr, exp_rd); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d; logic [1:0] r; bit ok;
    bus.bready = 0;
    bus.awaddr = 32'h10; bus.awvalid = 1; bus.wdata = 32'h99999999; bus.wstrb = 4'hF;
    bus.wvalid = 1;
    step();
    bus.awvalid = 0; bus.wvalid = 0;
    n_cmp++; if (bus.bvalid !== 1'b1) begin n_err++; $display("FAIL mid_bvalid: got %b want 1", bus.bvalid); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if ({bus.bvalid, bus.rvalid, bus.awready, bus.wready, bus.arready} !== 5'b0) begin n_err++; $display("FAIL mid_async_ctl: got %b want 00000", {bus.bvalid, bus.rvalid, bus.awready, bus.wready, bus.arready}); end
    n_cmp++; if ({wr_cnt, rd_cnt, bus.rdata} !== 64'h0) begin n_err++; $display("FAIL mid_async_data: got %h want 0", {wr_cnt, rd_cnt, bus.rdata}); end
    @(negedge clk); rst_n = 1'b1;
    step();
    exp_wr = 0; exp_rd = 0;
    n_cmp++; if ({bus.awready, bus.wready, bus.arready} !== 3'b111) begin n_err++; $display("FAIL mid_ready: got %b want 111", {bus.awready, bus.wready, bus.arready}); end
    bus.bready = 1;
    rd(32'h10, d, r, ok);
    n_cmp++; if (!ok || d !== 32'h0) begin n_err++; $display("FAIL mid_mem10: got %h want 0", d); end
    rd(32'h0, d, r, ok);
    n_cmp++; if (!ok || d !== 32'h0) begin n_err++; $display("FAIL mid_mem0: got %h want 0", d); end
    n_cmp++; if (wr_cnt !== 16'd0 || rd_cnt !== 16'd2) begin n_err++; $display("FAIL mid_cnt: got %0d/%0d want 0/2", wr_cnt, rd_cnt); end
  endtask

  initial begin
    test_reset();
    test_write_same_cycle();
    test_w_before_aw();
    test_partial_strobe();
    test_stall();
    test_back_to_back();
    test_out_of_range();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
